// File: rtl/axi_lite_param_regbank_if.sv
// AXI4-Lite bus bundle for the parametrised register bank.
// The master modport is the interconnect side; the slave modport is the register bank.
interface axi_lite_param_regbank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_param_regbank.sv
// Parametrised AXI4-Lite slave register bank with byte strobes, SLVERR decode,
// read-only status registers fed from reg_in, and per-register access pulses.
// Handshake rule: a transfer happens on a rising edge where VALID and READY are both 1;
// VALID, once raised by this block, holds its payload stable until that edge.
module axi_lite_param_regbank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axi_lite_param_regbank_if.slave        s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse,
    output logic                           wr_state_dbg,
    output logic                           rd_state_dbg
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    wr_state_e               wr_state_q, wr_state_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d, wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [IDX_W-1:0]        wr_idx;
    logic [NUM_REGS-1:0]     wr_hit;

    rd_state_e               rd_state_q, rd_state_d;
    logic                    arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [NUM_REGS-1:0]     rd_pulse_q, rd_pulse_d;
    logic [IDX_W-1:0]        rd_idx;
    logic [NUM_REGS-1:0]     rd_hit;
    logic [DATA_WIDTH-1:0]   rd_word;

    // wr_hit only contains writable, in-range registers, so an empty hit vector means SLVERR.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        wr_idx     = awaddr_q[ADDR_WIDTH-1:ADDR_LSB];
        wr_hit     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = (wr_idx == IDX_W'(i)) && !RO_MASK[i];
        end
        case (wr_state_q)
            WR_IDLE: begin
                if (s_axi.S_AXI_AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi.S_AXI_AWADDR;
                end
                if (s_axi.S_AXI_WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi.S_AXI_WDATA;
                    wstrb_d  = s_axi.S_AXI_WSTRB;
                end
                if (aw_held_q && w_held_q) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wr_hit[i] && wstrb_q[b]) begin
                                regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                    end
                    wr_pulse_d = wr_hit;
                    bresp_d    = (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d   = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        awready_d = (wr_state_d == WR_IDLE) && !aw_held_d;
        wready_d  = (wr_state_d == WR_IDLE) && !w_held_d;
    end

    // Reads sample regs_q, so a same-edge write commit is not visible in RDATA.
    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;
        rd_idx     = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
        rd_hit     = '0;
        rd_word    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_hit[i] = 1'b1;
                rd_word   = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
        case (rd_state_q)
            RD_IDLE: begin
                if (s_axi.S_AXI_ARVALID && arready_q) begin
                    rdata_d    = rd_word;
                    rresp_d    = (|rd_hit) ? RESP_OKAY : RESP_SLVERR;
                    rd_pulse_d = rd_hit;
                    rvalid_d   = 1'b1;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_axi.S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_pulse_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign wr_pulse            = wr_pulse_q;
    assign rd_pulse            = rd_pulse_q;
    assign wr_state_dbg        = (wr_state_q == WR_RESP);
    assign rd_state_dbg        = (rd_state_q == RD_RESP);

    // Protection bits, sub-word address bits and RW slices of reg_in carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr_q[ADDR_LSB-1:0],
                           s_axi.S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};
endmodule

// File: tb/tb_axi_lite_param_regbank.sv
// Directed bench for axi_lite_param_regbank: vector table plus stall and reset sequences.
module tb_axi_lite_param_regbank;
    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [255:0] reg_out;
    logic [255:0] reg_in;
    logic [7:0]   wr_pulse, rd_pulse;
    logic         wr_state_dbg, rd_state_dbg;

    int checks = 0;
    int errors = 0;
    int wr_cnt [8];
    logic [31:0] exp_q [$];

    axi_lite_param_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    axi_lite_param_regbank #(
        .DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(8), .RO_MASK(8'hC0)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus), .reg_out(reg_out), .reg_in(reg_in),
        .wr_pulse(wr_pulse), .rd_pulse(rd_pulse),
        .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
    );

    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        for (int i = 0; i < 8; i++) if (wr_pulse[i] === 1'b1) wr_cnt[i]++;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [7:0] pulse);
        int  n;
        bit  aw_fire, w_fire;
        n = 0;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 50) begin
            aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge ACLK); #1; n++;
            if (aw_fire) bus.S_AXI_AWVALID = 1'b0;
            if (w_fire)  bus.S_AXI_WVALID  = 1'b0;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        while (!bus.S_AXI_BVALID && n < 50) begin
            @(posedge ACLK); #1; n++;
        end
        check($sformatf("wr_bvalid_%0h", addr), bus.S_AXI_BVALID, 1);
        resp  = bus.S_AXI_BRESP;
        pulse = wr_pulse;
        @(posedge ACLK); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic issue_ar(input logic [7:0] addr);
        int n;
        bit fire;
        n = 0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        while (bus.S_AXI_ARVALID && n < 50) begin
            fire = bus.S_AXI_ARREADY;
            @(posedge ACLK); #1; n++;
            if (fire) bus.S_AXI_ARVALID = 1'b0;
        end
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic [7:0] pulse);
        issue_ar(addr);
        check($sformatf("rd_rvalid_%0h", addr), bus.S_AXI_RVALID, 1);
        data  = bus.S_AXI_RDATA;
        resp  = bus.S_AXI_RRESP;
        pulse = rd_pulse;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0]  rdata;
        logic [1:0]   resp;
        logic [7:0]   pulse;
        logic [255:0] exp_regs;
        int           exp_cnt [8];

        vecs[0]  = '{1'b1, 8'h00, 32'h1,        4'hF, 32'h0,        2'b00, 8'h01};
        vecs[1]  = '{1'b1, 8'h04, 32'h2,        4'hF, 32'h0,        2'b00, 8'h02};
        vecs[2]  = '{1'b1, 8'h08, 32'h3,        4'hF, 32'h0,        2'b00, 8'h04};
        vecs[3]  = '{1'b1, 8'h0C, 32'h4,        4'hF, 32'h0,        2'b00, 8'h08};
        vecs[4]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h1,        2'b00, 8'h01};
        vecs[5]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h2,        2'b00, 8'h02};
        vecs[6]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h3,        2'b00, 8'h04};
        vecs[7]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h4,        2'b00, 8'h08};
        vecs[8]  = '{1'b1, 8'h10, 32'hAABBCCDD, 4'h5, 32'h0,        2'b00, 8'h10};
        vecs[9]  = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h00BB00DD, 2'b00, 8'h10};
        vecs[10] = '{1'b1, 8'h18, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10, 8'h00};
        vecs[11] = '{1'b0, 8'h18, 32'h0,        4'h0, 32'h12345678, 2'b00, 8'h40};
        vecs[12] = '{1'b0, 8'h1C, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, 8'h80};
        vecs[13] = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h0,        2'b10, 8'h00};
        vecs[14] = '{1'b1, 8'h20, 32'hDEADBEEF, 4'hF, 32'h0,        2'b10, 8'h00};
        vecs[15] = '{1'b0, 8'h02, 32'h0,        4'h0, 32'h1,        2'b00, 8'h01};
        vecs[16] = '{1'b1, 8'h14, 32'h12345678, 4'h0, 32'h0,        2'b00, 8'h20};
        vecs[17] = '{1'b0, 8'h14, 32'h0,        4'h0, 32'h0,        2'b00, 8'h20};

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        reg_in = '0;
        reg_in[223:192] = 32'h12345678;
        reg_in[255:224] = 32'hCAFEF00D;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 0);
        check("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 0);
        check("rst_resp_data", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 0);
        check("rst_pulses", {wr_pulse, rd_pulse}, 0);
        check("rst_reg_out", reg_out, 0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, pulse);
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_wr_pulse", i), pulse, vecs[i].exp_pulse);
            end else begin
                exp_q.push_back(vecs[i].exp_data);
                axi_read(vecs[i].addr, rdata, resp, pulse);
                check($sformatf("vec%0d_rdata", i), rdata, exp_q.pop_front());
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_rd_pulse", i), pulse,
                      (vecs[i].exp_resp == 2'b00) ? vecs[i].exp_pulse : 8'h00);
            end
        end

        exp_regs = '0;
        exp_regs[31:0]    = 32'h1;
        exp_regs[63:32]   = 32'h2;
        exp_regs[95:64]   = 32'h3;
        exp_regs[127:96]  = 32'h4;
        exp_regs[159:128] = 32'h00BB00DD;
        check("table_reg_out", reg_out, exp_regs);
        exp_cnt = '{1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) check($sformatf("wr_cnt%0d", i), wr_cnt[i], exp_cnt[i]);

        // W leads AW by three cycles, then the response is stalled for five cycles.
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_WDATA  = 32'h5A5A0001;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        check("stall_wready_idle", bus.S_AXI_WREADY, 1);
        @(posedge ACLK); #1;
        bus.S_AXI_WVALID = 1'b0;
        check("stall_wready_held", bus.S_AXI_WREADY, 0);
        check("stall_awready_open", bus.S_AXI_AWREADY, 1);
        repeat (2) @(posedge ACLK);
        #1;
        bus.S_AXI_AWADDR  = 8'h14;
        bus.S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        check("stall_commit_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID}, 0);
        @(posedge ACLK); #1;
        check("stall_bresp", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
        check("stall_wr_pulse", wr_pulse, 8'h20);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall_cyc%0d", k),
                  {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b100);
            @(posedge ACLK); #1;
        end
        bus.S_AXI_BREADY = 1'b1;
        check("stall_bvalid_last", bus.S_AXI_BVALID, 1);
        @(posedge ACLK); #1;
        bus.S_AXI_BREADY = 1'b0;
        check("stall_b_done", {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b011);
        check("stall_wr_cnt5", wr_cnt[5], 2);
        check("stall_reg5", reg_out[191:160], 32'h5A5A0001);

        // Reset while a read response is outstanding.
        axi_write(8'h00, 32'h55, 4'hF, resp, pulse);
        check("rst_seq_bresp", resp, 2'b00);
        issue_ar(8'h00);
        check("rst_seq_rvalid", {bus.S_AXI_RVALID, bus.S_AXI_RDATA}, {1'b1, 32'h55});
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        check("rst_seq_rvalid_drop", bus.S_AXI_RVALID, 0);
        check("rst_seq_reg_out", reg_out, 0);
        @(posedge ACLK); #1;
        axi_read(8'h00, rdata, resp, pulse);
        check("rst_seq_read0", {rdata, resp, pulse}, {32'h0, 2'b00, 8'h01});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_param_regbank.md
Name: axi_lite_param_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; next generation of the fixed 4 x 32-bit register slave behind the processor IP's S00_AXI port.
- Generalises register count, data width and read-only mapping.
- Adds byte strobes, SLVERR responses, hardware status inputs and per-register access pulses.
- Sits between the AXI interconnect / master VIP and the processing core: core consumes reg_out and drives reg_in.

Parameters:
- DATA_WIDTH, 32, AXI data width; legal values 32 or 64.
- NUM_REGS, 8, number of registers; legal range 1..64.
- ADDR_WIDTH, 8, AXI address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from reg_in slice i.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous active-high reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- reg_out  out  NUM_REGS*DATA_WIDTH  RW register contents; slice i = register i; RO slices drive 0.
- reg_in  in  NUM_REGS*DATA_WIDTH  status values for RO registers; RW slices unused.
- wr_pulse  out  NUM_REGS  one-cycle pulse on a successful write to register i.
- rd_pulse  out  NUM_REGS  one-cycle pulse on an accepted read of register i (OKAY only).

Behaviour:
- Reset (ARESET=1 at an edge) forces: all RW registers 0; AWREADY, WREADY, BVALID, ARREADY, RVALID, wr_pulse, rd_pulse = 0; BRESP, RRESP, RDATA = 0; both FSMs to IDLE.
- Reset mid-transaction abandons it; any in-flight BVALID/RVALID drops on the next edge.
- Address decode: ADDR_LSB = log2(DATA_WIDTH/8); idx = addr[ADDR_WIDTH-1:ADDR_LSB]; low bits ignored, so unaligned accesses alias to the containing word.
- Write FSM, states WR_IDLE and WR_RESP:
  - WR_IDLE: AWREADY=1 while no address is held; WREADY=1 while no data is held.
  - AW and W may arrive in either order or in the same cycle; each is latched into a holding register when its handshake completes.
  - In the first cycle both are held, the write commits.
    - If idx < NUM_REGS and RO_MASK[idx]=0: each byte with WSTRB=1 is updated; wr_pulse[idx]=1 for exactly that cycle; BRESP=OKAY.
    - Otherwise: no register changes; no pulse; BRESP=SLVERR.
  - BVALID rises on the next edge; FSM enters WR_RESP with AWREADY=WREADY=0.
  - WR_RESP: BVALID and BRESP hold until BREADY=1, then FSM returns to WR_IDLE and the holding flags clear.
  - WSTRB=0 still returns OKAY and produces wr_pulse, but no data changes.
- Read FSM, states RD_IDLE and RD_RESP:
  - RD_IDLE: ARREADY=1.
  - On AR handshake at edge T: RDATA and RRESP are registered and RVALID=1 after T; FSM enters RD_RESP with ARREADY=0.
  - RDATA selection: RW register, reg_in slice for RO registers, or 0 with SLVERR when idx >= NUM_REGS.
  - rd_pulse[idx] is high for the cycle after T (OKAY only).
  - RD_RESP: RDATA holds stable until RVALID and RREADY are both 1, then FSM returns to RD_IDLE. Maximum throughput is one read per 2 cycles.
- Read and write channels are independent and may proceed concurrently.
  - If a write commit and an AR handshake hit the same register on the same edge, RDATA returns the pre-write value.
- reg_out updates on the edge after the commit and is continuously registered.

Test Plan:
- Defaults (32-bit, 8 regs, RO_MASK=8'hC0): write 1,2,3,4 to addresses 0x0,0x4,0x8,0xC -> BRESP=OKAY each time; read-back returns 1,2,3,4; wr_pulse bits 0..3 each pulse once.
- Write 0xAABBCCDD to 0x10 with WSTRB=4'b0101 after reset -> reg 4 reads 0x00BB00DD.
- Drive reg_in slice 6 = 0x12345678; write 0xFFFFFFFF to 0x18 -> BRESP=SLVERR, no wr_pulse; read 0x18 returns 0x12345678 with OKAY and rd_pulse[6]=1.
- Read 0x20 -> RRESP=SLVERR, RDATA=0; write 0x20 -> SLVERR, all registers unchanged.
- Assert W three cycles before AW, with BREADY held low 5 cycles -> write commits once; BVALID stays high through the stall; AWREADY and WREADY stay 0 until the B handshake.
- Assert ARESET for 1 cycle while RVALID=1 and reg 0=0x55 -> RVALID=0 next cycle; reg 0 reads 0 afterwards.
